// File: rtl/control_pkg.sv
// ============================================================================
//  control_pkg
//  Opcodes, control-word bit positions and named microcode words shared
//  by the control sequencer of the 8-bit computer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package control_pkg;

  localparam int STEP_W = 3;

  localparam logic [3:0] c_OP_NOP = 4'b0000;
  localparam logic [3:0] c_OP_LDA = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0011;
  localparam logic [3:0] c_OP_STA = 4'b0100;
  localparam logic [3:0] c_OP_LDI = 4'b0101;
  localparam logic [3:0] c_OP_JMP = 4'b0110;
  localparam logic [3:0] c_OP_JC  = 4'b0111;
  localparam logic [3:0] c_OP_JZ  = 4'b1000;
  localparam logic [3:0] c_OP_OUT = 4'b1110;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  localparam int c_BIT_HLT = 15;
  localparam int c_BIT_MI  = 14;
  localparam int c_BIT_RI  = 13;
  localparam int c_BIT_RO  = 12;
  localparam int c_BIT_IO  = 11;
  localparam int c_BIT_II  = 10;
  localparam int c_BIT_AI  = 9;
  localparam int c_BIT_AO  = 8;
  localparam int c_BIT_EO  = 7;
  localparam int c_BIT_SU  = 6;
  localparam int c_BIT_BI  = 5;
  localparam int c_BIT_OI  = 4;
  localparam int c_BIT_CE  = 3;
  localparam int c_BIT_CO  = 2;
  localparam int c_BIT_J   = 1;
  localparam int c_BIT_FI  = 0;

  localparam logic [15:0] c_CW_HLT = 16'h0001 << c_BIT_HLT;
  localparam logic [15:0] c_CW_MI  = 16'h0001 << c_BIT_MI;
  localparam logic [15:0] c_CW_RI  = 16'h0001 << c_BIT_RI;
  localparam logic [15:0] c_CW_RO  = 16'h0001 << c_BIT_RO;
  localparam logic [15:0] c_CW_IO  = 16'h0001 << c_BIT_IO;
  localparam logic [15:0] c_CW_II  = 16'h0001 << c_BIT_II;
  localparam logic [15:0] c_CW_AI  = 16'h0001 << c_BIT_AI;
  localparam logic [15:0] c_CW_AO  = 16'h0001 << c_BIT_AO;
  localparam logic [15:0] c_CW_EO  = 16'h0001 << c_BIT_EO;
  localparam logic [15:0] c_CW_SU  = 16'h0001 << c_BIT_SU;
  localparam logic [15:0] c_CW_BI  = 16'h0001 << c_BIT_BI;
  localparam logic [15:0] c_CW_OI  = 16'h0001 << c_BIT_OI;
  localparam logic [15:0] c_CW_CE  = 16'h0001 << c_BIT_CE;
  localparam logic [15:0] c_CW_CO  = 16'h0001 << c_BIT_CO;
  localparam logic [15:0] c_CW_J   = 16'h0001 << c_BIT_J;
  localparam logic [15:0] c_CW_FI  = 16'h0001 << c_BIT_FI;

  localparam logic [15:0] c_FETCH0   = c_CW_CO | c_CW_MI;
  localparam logic [15:0] c_FETCH1   = c_CW_RO | c_CW_II | c_CW_CE;
  localparam logic [15:0] c_ADDR_IR  = c_CW_IO | c_CW_MI;
  localparam logic [15:0] c_RAM_TO_A = c_CW_RO | c_CW_AI;
  localparam logic [15:0] c_RAM_TO_B = c_CW_RO | c_CW_BI;
  localparam logic [15:0] c_ALU_ADD  = c_CW_EO | c_CW_AI | c_CW_FI;
  localparam logic [15:0] c_ALU_SUB  = c_CW_EO | c_CW_AI | c_CW_SU | c_CW_FI;
  localparam logic [15:0] c_A_TO_RAM = c_CW_AO | c_CW_RI;
  localparam logic [15:0] c_IR_TO_A  = c_CW_IO | c_CW_AI;
  localparam logic [15:0] c_JUMP     = c_CW_IO | c_CW_J;
  localparam logic [15:0] c_A_TO_OUT = c_CW_AO | c_CW_OI;
  localparam logic [15:0] c_HALT     = c_CW_HLT;

endpackage

`default_nettype wire

// File: rtl/step_counter.sv
// ============================================================================
//  step_counter
//  Modulo-COUNT T-state counter with enable and synchronous clear.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module step_counter #(
  parameter int COUNT = 5,
  parameter int W     = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      if (clear || r_count == W'(COUNT - 1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
//  control_sequencer
//  Microcode sequencer: steps T-states and decodes the 16-bit control word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module control_sequencer
  import control_pkg::*;
#(
  parameter int STEP_COUNT = 5,
  parameter bit EARLY_END  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       control,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  function automatic logic [15:0] decode(input logic [STEP_W-1:0] s,
                                         input logic [3:0]        op,
                                         input logic              cf,
                                         input logic              zf);
    logic [15:0] cw;
    cw = '0;
    case (s)
      3'd0: cw = c_FETCH0;
      3'd1: cw = c_FETCH1;
      3'd2: begin
        case (op)
          c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: cw = c_ADDR_IR;
          c_OP_LDI: cw = c_IR_TO_A;
          c_OP_JMP: cw = c_JUMP;
          c_OP_JC:  cw = cf ? c_JUMP : '0;
          c_OP_JZ:  cw = zf ? c_JUMP : '0;
          c_OP_OUT: cw = c_A_TO_OUT;
          c_OP_HLT: cw = c_HALT;
          default:  cw = '0;
        endcase
      end
      3'd3: begin
        case (op)
          c_OP_LDA:           cw = c_RAM_TO_A;
          c_OP_ADD, c_OP_SUB: cw = c_RAM_TO_B;
          c_OP_STA:           cw = c_A_TO_RAM;
          default:            cw = '0;
        endcase
      end
      3'd4: begin
        case (op)
          c_OP_ADD: cw = c_ALU_ADD;
          c_OP_SUB: cw = c_ALU_SUB;
          default:  cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

  logic              r_halted;
  logic [STEP_W-1:0] w_step_next;
  logic              w_halt_set;
  logic              w_enable;
  logic              w_early_end;

  assign w_step_next = step + 1'b1;
  assign w_halt_set  = run && !r_halted && (step == 3'd2) && (opcode == c_OP_HLT);
  // The halting edge must not advance the step, so step freezes at 2.
  assign w_enable    = run && !r_halted && !w_halt_set;
  assign w_early_end = EARLY_END && (step >= 3'd2) &&
                       (decode(w_step_next, opcode, carry_flag, zero_flag) == 16'h0000);

  step_counter #(
    .COUNT (STEP_COUNT),
    .W     (STEP_W)
  ) u_step_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (w_enable),
    .clear  (w_early_end),
    .count  (step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end
  end

  assign halted = r_halted;

  // Reset gates the word combinationally so it drops in the same cycle.
  always_comb begin
    control = '0;
    if (reset) begin
      control = '0;
    end else if (r_halted) begin
      control = c_HALT;
    end else if (!run) begin
      control = '0;
    end else begin
      control = decode(step, opcode, carry_flag, zero_flag);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  tb_control_sequencer
//  Directed and randomized checks of control_sequencer against a table model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  opcode1, opcode2;
  logic        carry_flag, zero_flag;
  logic [15:0] control1, control2;
  logic [2:0]  step1, step2;
  logic        halted1, halted2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ucode [16][3];
  int m_step1, m_step2;
  bit m_halt1, m_halt2;

  always #5 clock = ~clock;

  control_sequencer #(.STEP_COUNT(5), .EARLY_END(1'b1)) dut1 (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode1),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .control(control1), .step(step1), .halted(halted1)
  );

  control_sequencer #(.STEP_COUNT(5), .EARLY_END(1'b0)) dut2 (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode2),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .control(control2), .step(step2), .halted(halted2)
  );

  function automatic logic [15:0] word(int s, logic [3:0] op, logic cf, logic zf);
    if (s == 0) return 16'h4004;
    if (s == 1) return 16'h1408;
    if (s < 2 || s > 4) return 16'h0000;
    if (op == 4'h7 && !cf) return 16'h0000;
    if (op == 4'h8 && !zf) return 16'h0000;
    return ucode[op][s-2];
  endfunction

  // Instruction length: fetch plus microcode up to the last non-empty word.
  function automatic int instr_len(logic [3:0] op, logic cf, logic zf, bit ee);
    int n;
    if (!ee) return 5;
    n = 0;
    for (int k = 0; k < 3; k++)
      if (word(k + 2, op, cf, zf) != 16'h0000) n = k + 1;
    return (2 + n < 3) ? 3 : 2 + n;
  endfunction

  function automatic logic [15:0] exp_ctl(int s, bit h, logic [3:0] op);
    if (reset) return 16'h0000;
    if (h) return 16'h8000;
    if (!run) return 16'h0000;
    return word(s, op, carry_flag, zero_flag);
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
    check("ctl1", control1, exp_ctl(m_step1, m_halt1, opcode1));
    check("step1", {13'b0, step1}, 16'(m_step1));
    check("halt1", {15'b0, halted1}, {15'b0, m_halt1});
    check("ctl2", control2, exp_ctl(m_step2, m_halt2, opcode2));
    check("step2", {13'b0, step2}, 16'(m_step2));
    check("halt2", {15'b0, halted2}, {15'b0, m_halt2});
  endtask

  task automatic edge_step();
    if (reset) begin
      m_step1 = 0; m_halt1 = 0; m_step2 = 0; m_halt2 = 0;
    end else if (run) begin
      if (!m_halt1) begin
        if (m_step1 == 2 && opcode1 == 4'hF) m_halt1 = 1;
        else m_step1 = (m_step1 + 1 >= instr_len(opcode1, carry_flag, zero_flag, 1)) ? 0 : m_step1 + 1;
      end
      if (!m_halt2) begin
        if (m_step2 == 2 && opcode2 == 4'hF) m_halt2 = 1;
        else m_step2 = (m_step2 + 1 >= instr_len(opcode2, carry_flag, zero_flag, 0)) ? 0 : m_step2 + 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ctl1", control1, 16'h0000);
    check("rst_step1", {13'b0, step1}, 16'h0000);
    check("rst_halt1", {15'b0, halted1}, 16'h0000);
    check("rst_ctl2", control2, 16'h0000);
    m_step1 = 0; m_halt1 = 0; m_step2 = 0; m_halt2 = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic seq_check(string tag, bit sel, input logic [15:0] exp_q[$]);
    foreach (exp_q[i]) begin
      settle();
      check(tag, sel ? control2 : control1, exp_q[i]);
      edge_step();
    end
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 3; k++) ucode[o][k] = 16'h0000;
    ucode[1]  = '{16'h4800, 16'h1200, 16'h0000};
    ucode[2]  = '{16'h4800, 16'h1020, 16'h0281};
    ucode[3]  = '{16'h4800, 16'h1020, 16'h02C1};
    ucode[4]  = '{16'h4800, 16'h2100, 16'h0000};
    ucode[5]  = '{16'h0A00, 16'h0000, 16'h0000};
    ucode[6]  = '{16'h0802, 16'h0000, 16'h0000};
    ucode[7]  = '{16'h0802, 16'h0000, 16'h0000};
    ucode[8]  = '{16'h0802, 16'h0000, 16'h0000};
    ucode[14] = '{16'h0110, 16'h0000, 16'h0000};
    ucode[15] = '{16'h8000, 16'h0000, 16'h0000};

    m_step1 = 0; m_halt1 = 0; m_step2 = 0; m_halt2 = 0;
    reset = 1'b1; run = 1'b1; opcode1 = 4'h0; opcode2 = 4'h0;
    carry_flag = 1'b0; zero_flag = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    settle();
    reset = 1'b0;
    settle();
    check("first_t0", control1, 16'h4004);

    // LDA: 4-cycle instruction
    opcode1 = 4'h1;
    seq_check("lda", 0, '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004});

    // SUB: full 5 steps then wrap
    do_reset();
    opcode1 = 4'h3;
    seq_check("sub", 0, '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1, 16'h4004});

    // JC both ways
    do_reset();
    opcode1 = 4'h7; carry_flag = 1'b0;
    seq_check("jc_nc", 0, '{16'h4004, 16'h1408, 16'h0000, 16'h4004});
    do_reset();
    carry_flag = 1'b1;
    seq_check("jc_c", 0, '{16'h4004, 16'h1408, 16'h0802, 16'h4004});

    // Reset mid-ADD at step 3
    do_reset();
    opcode1 = 4'h2;
    repeat (3) begin settle(); edge_step(); end
    check("add_at_s3", {13'b0, step1}, 16'h0003);
    do_reset();
    settle();
    check("after_rst", control1, 16'h4004);

    // run low at step 1
    do_reset();
    opcode1 = 4'h5;
    settle(); edge_step();
    run = 1'b0;
    repeat (3) begin
      settle();
      check("hold_ctl", control1, 16'h0000);
      check("hold_step", {13'b0, step1}, 16'h0001);
      edge_step();
    end
    run = 1'b1;
    settle();
    check("resume", control1, 16'h1408);

    // HLT at step 2 with run falling: no halt
    do_reset();
    opcode1 = 4'hF;
    repeat (2) begin settle(); edge_step(); end
    run = 1'b0;
    settle(); edge_step();
    check("hlt_norun", {15'b0, halted1}, 16'h0000);
    run = 1'b1;

    // HLT latches and freezes
    do_reset();
    seq_check("hlt", 0, '{16'h4004, 16'h1408, 16'h8000});
    repeat (10) begin
      settle();
      check("hlt_ctl", control1, 16'h8000);
      check("hlt_step", {13'b0, step1}, 16'h0002);
      check("hlt_flag", {15'b0, halted1}, 16'h0001);
      edge_step();
    end
    do_reset();
    settle();

    // EARLY_END=0: LDI takes all 5 steps
    opcode1 = 4'h0; opcode2 = 4'h5;
    seq_check("ldi_full", 1, '{16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000, 16'h4004});

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      run        = ($urandom_range(7) != 0);
      carry_flag = $urandom_range(1);
      zero_flag  = $urandom_range(1);
      if (m_step1 == 0) opcode1 = 4'($urandom_range(15));
      if (m_step2 == 0) opcode2 = 4'($urandom_range(15));
      if (((m_halt1 || m_halt2) && $urandom_range(3) == 0) || $urandom_range(63) == 0)
        do_reset();
      settle();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Microcode sequencer for the 8-bit computer. Each clock it steps through the T-states of the current instruction and drives the 16-bit control word. That word supplies the enable, set and load strobes of the gated register latches, ALU, RAM and program counter downstream. It reads the opcode from the instruction register and the carry/zero flags, ends instructions early, and latches a halt state.

## Interface
Parameters:
- STEP_COUNT, default 5: number of T-states. The step counter wraps from STEP_COUNT-1 to 0.
- EARLY_END, default 1: when 1, the sequencer skips the trailing all-zero T-states.

Ports:
- clock  in  1  system clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- run  in  1  advance enable. When 0, the step holds and the control word is forced to 0.
- opcode  in  4  instruction register high nibble. Valid from step 2.
- carry_flag  in  1  ALU carry flag register output.
- zero_flag  in  1  ALU zero flag register output.
- control  out  16  control word, bits [15:0]: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
- step  out  3  current T-state.
- halted  out  1  halt latched.

## Operation
- Registered state is step and halted. control is a combinational decode of step, halted, run, opcode and the flags. Consumers sample control on the next rising edge.
- Priority for control: reset → 0, then halted → 16'h8000, then run=0 → 0, otherwise decode(step).
- Fetch steps, for every opcode:
  - T0 = CO|MI (16'h4004)
  - T1 = RO|II|CE (16'h1408)
- Execute steps, T2 onward:
  - LDA 0001: IO|MI (4800), RO|AI (1200)
  - ADD 0010: IO|MI, RO|BI (1020), EO|AI|FI (0281)
  - SUB 0011: IO|MI, RO|BI, EO|AI|SU|FI (02C1)
  - STA 0100: IO|MI, AO|RI (2100)
  - LDI 0101: IO|AI (0A00)
  - JMP 0110: IO|J (0802)
  - JC 0111: IO|J only if carry_flag, else 0
  - JZ 1000: IO|J only if zero_flag, else 0
  - OUT 1110: AO|OI (0110)
  - HLT 1111: HLT (8000)
  - NOP 0000 and all undefined opcodes: 0
- Step advance on a rising edge with run=1 and halted=0:
  - step = STEP_COUNT-1 → 0.
  - Else, if EARLY_END=1, step ≥ 2, and decode(step+1) = 0 → 0.
  - Else step+1.
- Halt: a rising edge with run=1, step=2 and opcode=1111 sets halted=1. step freezes at 2. Only reset clears halted.

## Timing
- Reset values: step=0, halted=0, control=0. After reset is released, the first cycle presents the T0 word.
- One T-state per enabled clock. Instruction lengths with EARLY_END=1:
  - NOP, LDI, JMP, JC, JZ, OUT: 3 cycles
  - LDA, STA: 4 cycles
  - ADD, SUB: 5 cycles
- With EARLY_END=0, every instruction takes STEP_COUNT cycles.
- Flags and opcode are combinational inputs. A change mid-step is reflected in control in the same cycle.
- run deasserted mid-instruction: step holds and control=0. When run returns, the sequencer resumes at the held step.
- Reset asserted mid-instruction: step=0, halted=0 and control=0 immediately, not on the next edge.
- Simultaneous HLT at step 2 with run falling: no edge is enabled, so halted does not set.

## Structure
- Shared package control_pkg holds:
  - opcode constants
  - control-bit index constants and named control words (FETCH0, FETCH1, …)
  - STEP_W = 3
- Sub-module step_counter: mod-STEP_COUNT counter with async reset, enable (run & ~halted) and synchronous clear (early end).
- Microcode decode stays a function in control_sequencer. It is reused for the look-ahead decode(step+1).

## Test plan
- Reset mid-sequence: assert reset at step 3 of ADD → step=0, control=0 and halted=0 in the same cycle. After release, control=4004.
- LDA, opcode 0001: control sequence 4004, 1408, 4800, 1200, then 4004 (4-cycle instruction).
- SUB, opcode 0011: sequence 4004, 1408, 4800, 1020, 02C1, then wrap to step 0.
- JC, opcode 0111:
  - carry_flag=0 → step 2 control 0000, then step 0.
  - carry_flag=1 → step 2 control 0802.
- HLT, opcode 1111: at step 2, control 8000 and halted=1 after the edge. step stays 2 and control stays 8000 for 10 cycles. Reset clears both.
- run=0 at step 1 for 3 cycles → control 0000 and step 1 held. On run=1, control returns to 1408.
- EARLY_END=0 with LDI → 5 cycles; control 0000 at steps 3 and 4.
